// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types and constants for the instruction-register
//               load path (opcode, operand and address types, depth).
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

  typedef logic        [3:0]  opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;

  localparam int unsigned NUM_ENTRIES = 32;

  // Occupancy value at which the register file is considered full
  localparam logic [5:0] c_count_full = 6'(NUM_ENTRIES);

  // Opcode encodings used by requesters
  localparam opcode_t c_op_nop = 4'h0;
  localparam opcode_t c_op_add = 4'h1;
  localparam opcode_t c_op_sub = 4'h2;
  localparam opcode_t c_op_mul = 4'h3;

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/arb2_rr.sv
`default_nettype none
// ============================================================================
// Module      : arb2_rr
// Description : Two-way arbiter. A lone request wins outright; on contention
//               the requester that did not win last time is granted.
//               Output grant is one-hot (or zero when nothing requests).
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Pick the single requester, or the one opposite last_grant on contention
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule : arb2_rr
`default_nettype wire

// File: rtl/instr_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : instr_load_arbiter
// Description : Arbitrates two instruction requesters onto a single
//               registered instruction-register write port. Tracks occupancy
//               (0..32) and a wrapping write address; flush empties it.
//               Build option: INSTR_ARB_ROUND_ROBIN_EN
//                 defined   -> round-robin on contention (req0 wins first)
//                 undefined -> fixed priority, req0 always wins
// Revision    : 1.0 - initial release
// ============================================================================
module instr_load_arbiter
  import instr_register_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      req0_valid,
  input  logic      req1_valid,
  input  opcode_t   req0_opcode,
  input  opcode_t   req1_opcode,
  input  operand_t  req0_operand_a,
  input  operand_t  req0_operand_b,
  input  operand_t  req1_operand_a,
  input  operand_t  req1_operand_b,
  output logic      req0_ready,
  output logic      req1_ready,
  input  logic      flush,
  output logic      load_en,
  output opcode_t   opcode,
  output operand_t  operand_a,
  output operand_t  operand_b,
  output address_t  write_pointer,
  output logic [5:0] count,
  output logic      full,
  output logic      grant_id
);

  logic       r_load_en;
  opcode_t    r_opcode;
  operand_t   r_operand_a;
  operand_t   r_operand_b;
  address_t   r_write_pointer;
  address_t   r_next_addr;
  logic [5:0] r_count;
  logic       r_grant_id;

  logic       w_block;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_fire;
  logic       w_sel;
  logic       w_last_grant;
  logic       w_full;

  assign w_full  = (r_count == c_count_full);
  // No grant while full, flushing or held in reset
  assign w_block = w_full | flush | ~reset_n;
  assign w_req   = {req1_valid, req0_valid} & {2{~w_block}};

  arb2_rr u_arb (
    .req        (w_req),
    .last_grant (w_last_grant),
    .gnt        (w_gnt)
  );

  assign w_fire = |w_gnt;
  assign w_sel  = w_gnt[1];

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Remember the most recent winner; reset value 1 lets req0 win first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_fire && !flush) begin
      r_last_grant <= w_sel;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  // Fixed priority: presenting last_grant=1 permanently favours req0
  assign w_last_grant = 1'b1;
`endif

  // Write port, address and occupancy registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_load_en       <= 1'b0;
      r_opcode        <= '0;
      r_operand_a     <= '0;
      r_operand_b     <= '0;
      r_write_pointer <= '0;
      r_next_addr     <= '0;
      r_count         <= '0;
      r_grant_id      <= 1'b0;
    end else if (flush) begin
      r_load_en       <= 1'b0;
      r_write_pointer <= '0;
      r_next_addr     <= '0;
      r_count         <= '0;
    end else begin
      r_load_en <= w_fire;
      if (w_fire) begin
        r_opcode        <= w_sel ? req1_opcode    : req0_opcode;
        r_operand_a     <= w_sel ? req1_operand_a : req0_operand_a;
        r_operand_b     <= w_sel ? req1_operand_b : req0_operand_b;
        r_grant_id      <= w_sel;
        r_write_pointer <= r_next_addr;
        r_next_addr     <= r_next_addr + 5'd1;
        if (r_count != c_count_full) begin
          r_count <= r_count + 6'd1;
        end
      end
    end
  end

  assign req0_ready    = w_gnt[0];
  assign req1_ready    = w_gnt[1];
  assign load_en       = r_load_en;
  assign opcode        = r_opcode;
  assign operand_a     = r_operand_a;
  assign operand_b     = r_operand_b;
  assign write_pointer = r_write_pointer;
  assign count         = r_count;
  assign full          = w_full;
  assign grant_id      = r_grant_id;

endmodule : instr_load_arbiter
`default_nettype wire
